// File: rtl/token_arb_pkg.sv
// Shared types and constants for the token expander arbiter.
package token_arb_pkg;

    localparam int unsigned MULT_W_DEFAULT = 3;
    localparam int unsigned STAT_W         = 16;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_e;

endpackage : token_arb_pkg

// File: rtl/token_expander_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot pick over req, rotating priority pointer.
// The pointer moves past the granted requester only when advance is high.
module rr_arbiter #(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic             found;
    int unsigned      idx;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[IDX_W'(idx)]) begin
                found                 = 1'b1;
                grant[IDX_W'(idx)]    = 1'b1;
                grant_idx             = IDX_W'(idx);
            end
        end
    end

    // Pointer: winner's successor becomes highest priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

endmodule : rr_arbiter

// File: rtl/token_expander_arbiter.sv
// Shares one token expander between N_REQ requesters. Each accepted request
// becomes mult_cfg[i] tagged output tokens, one per cycle under out_ready.
// Optional macro TOKEN_ARB_STATS_EN adds per-requester token counters.
module token_expander_arbiter
    import token_arb_pkg::*;
#(
    parameter  int unsigned N_REQ  = 4,
    parameter  int unsigned MULT_W = MULT_W_DEFAULT,
    localparam int unsigned ID_W   = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*MULT_W-1:0]   mult_cfg,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ID_W-1:0]           out_id,
    output logic                      out_last,
    output logic                      busy
`ifdef TOKEN_ARB_STATS_EN
    ,
    output logic [N_REQ*STAT_W-1:0]   stat_tokens
`endif
);

    state_e             state_q, state_d;
    logic [MULT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [MULT_W-1:0]  mult_arr [N_REQ];
    logic [N_REQ-1:0]   grant;
    logic [ID_W-1:0]    grant_idx;
    logic               fire;
    logic               can_accept;
    logic               accept;

    for (genvar g = 0; g < N_REQ; g++) begin : g_cfg
        assign mult_arr[g] = mult_cfg[g*MULT_W +: MULT_W];
    end

    rr_arbiter #(.N(N_REQ)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Outputs decode straight from registered state.
    assign out_valid = (state_q == EXPAND);
    assign busy      = (state_q == EXPAND);
    assign out_last  = (state_q == EXPAND) && (cnt_q == MULT_W'(1));
    assign out_id    = id_q;
    assign fire      = out_valid & out_ready;

    // Accept in IDLE or on the final token handshake (zero-bubble chaining).
    assign can_accept = rst & ((state_q == IDLE) | (fire & (cnt_q == MULT_W'(1))));
    assign req_ready  = grant & {N_REQ{can_accept}};
    assign accept     = |req_ready;

    // Next-state: count down the burst, load a new one on accept.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        if (fire) begin
            cnt_d = cnt_q - MULT_W'(1);
            if (cnt_q == MULT_W'(1)) begin
                state_d = IDLE;
            end
        end
        if (accept) begin
            id_d    = grant_idx;
            cnt_d   = mult_arr[grant_idx];
            state_d = (mult_arr[grant_idx] != '0) ? EXPAND : IDLE;
        end
    end

    // State, counter and owner registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
        end
    end

`ifdef TOKEN_ARB_STATS_EN
    for (genvar g = 0; g < N_REQ; g++) begin : g_stat
        logic [STAT_W-1:0] tok_cnt;

        // Saturating count of tokens delivered for requester g.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                tok_cnt <= '0;
            end else if (fire && (id_q == ID_W'(g)) && (tok_cnt != '1)) begin
                tok_cnt <= tok_cnt + STAT_W'(1);
            end
        end

        assign stat_tokens[g*STAT_W +: STAT_W] = tok_cnt;
    end
`endif

endmodule : token_expander_arbiter

// File: tb/tb_token_expander_arbiter.sv
// Randomized + directed bench with a token-queue reference model.
// Build with +define+TOKEN_ARB_STATS_EN to also check stat_tokens.
module tb_token_expander_arbiter;

    localparam int N  = 4;
    localparam int MW = 3;
    localparam int IW = 2;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*MW-1:0]   mult_cfg;
    logic              out_valid;
    logic              out_ready;
    logic [IW-1:0]     out_id;
    logic              out_last;
    logic              busy;
`ifdef TOKEN_ARB_STATS_EN
    logic [N*16-1:0]   stat_tokens;
`endif

    token_expander_arbiter #(.N_REQ(N), .MULT_W(MW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .mult_cfg  (mult_cfg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_last  (out_last),
        .busy      (busy)
`ifdef TOKEN_ARB_STATS_EN
        ,
        .stat_tokens (stat_tokens)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int id;
        bit last;
    } tok_t;

    tok_t exp_q[$];
    int   ptr;
    int   stat_m[N];
    int   n_checks;
    int   n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        ptr = 0;
        for (int i = 0; i < N; i++) stat_m[i] = 0;
    endtask

    task automatic set_cfg(input int i, input int v);
        mult_cfg[i*MW +: MW] = MW'(v);
    endtask

    // Compare this cycle's outputs against the model, then advance the model.
    task automatic model_cycle();
        int  n;
        bit  ev;
        bit  fire;
        bit  can;
        int  g;
        int  m;
        int  idx;
        logic [N-1:0] exp_rdy;
        n  = exp_q.size();
        ev = (n > 0);
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("busy", 32'(busy), 32'(ev));
        chk("out_last", 32'(out_last), ev ? 32'(exp_q[0].last) : 32'd0);
        if (ev) chk("out_id", 32'(out_id), 32'(exp_q[0].id));
        fire = ev && out_ready;
        can  = !ev || (fire && n == 1);
        g    = -1;
        if (can) begin
            for (int k = 0; k < N; k++) begin
                idx = (ptr + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (fire) begin
            if (stat_m[exp_q[0].id] < 65535) stat_m[exp_q[0].id]++;
            void'(exp_q.pop_front());
        end
        if (g >= 0) begin
            m = int'(mult_cfg[g*MW +: MW]);
            for (int j = 0; j < m; j++) exp_q.push_back('{id: g, last: (j == m - 1)});
            ptr = (g + 1) % N;
        end
    endtask

    // One clock: inputs applied at posedge+1, checked at negedge.
    task automatic step(input logic [N-1:0] rv, input logic ordy);
        req_valid = rv;
        out_ready = ordy;
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() > 0 && budget < 100) begin
            step('0, 1'b1);
            budget++;
        end
        if (exp_q.size() > 0) chk("drain_budget", 32'(exp_q.size()), 32'd0);
        step('0, 1'b1);
    endtask

    task automatic check_stats();
`ifdef TOKEN_ARB_STATS_EN
        for (int i = 0; i < N; i++) begin
            chk("stat_tokens", 32'(stat_tokens[i*16 +: 16]), 32'(stat_m[i]));
        end
`endif
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        req_valid = '1;
        out_ready = 1'b1;
        mult_cfg  = '0;
        model_reset();

        // Reset state, with requests pending.
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        check_stats();
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single request, factor 3.
        set_cfg(2, 3);
        step(4'b0100, 1'b1);
        for (int i = 0; i < 4; i++) step('0, 1'b1);

        // Round-robin fairness, factor 1 everywhere, no bubbles.
        for (int i = 0; i < N; i++) set_cfg(i, 1);
        for (int i = 0; i < 10; i++) step('1, 1'b1);
        drain();

        // Backpressure mid-burst.
        for (int i = 0; i < N; i++) set_cfg(i, 2);
        step(4'b0001, 1'b1);
        for (int i = 0; i < 5; i++) step('0, 1'b0);
        for (int i = 0; i < 3; i++) step('0, 1'b1);

        // Config change after accept does not affect the burst.
        set_cfg(0, 5);
        step(4'b0001, 1'b1);
        set_cfg(0, 1);
        for (int i = 0; i < 7; i++) step('0, 1'b1);

        // Async reset at token 3 of a 6-token burst.
        set_cfg(0, 6);
        step(4'b0001, 1'b1);
        for (int i = 0; i < 3; i++) step('0, 1'b1);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        req_valid = '1;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_out_last", 32'(out_last), 32'd0);
        chk("arst_out_id", 32'(out_id), 32'd0);
        chk("arst_req_ready", 32'(req_ready), 32'd0);
        model_reset();
        check_stats();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        @(posedge clk);
        #1;

        // Zero factor: requester 0 bursts, requester 1 consumed silently.
        set_cfg(0, 2);
        set_cfg(1, 0);
        set_cfg(2, 1);
        set_cfg(3, 1);
        step(4'b0011, 1'b1);
        step(4'b0010, 1'b1);
        step(4'b0010, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b1111, 1'b1);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            mult_cfg = (N*MW)'($urandom);
            step(N'($urandom), ($urandom_range(0, 3) != 0));
        end
        drain();
        check_stats();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_token_expander_arbiter

// File: doc/token_expander_arbiter.md
Name: token_expander_arbiter

Overview:
- Shares one token expander between N_REQ requesters.
- Each accepted request token is expanded into mult_cfg output tokens, tagged with the requester id and emitted one per cycle under out_ready backpressure.
- Grants rotate round-robin and chain back-to-back with no idle cycle.
- Sits in front of the token-doubling datapath as its scheduler and configurator.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- MULT_W, 3, width of each per-requester expansion factor (factor range 0..2**MULT_W-1).
- ID_W, $clog2(N_REQ), width of out_id (derived, not overridden).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  N_REQ  request token per requester.
- req_ready  output  N_REQ  one-hot accept; handshake completes on req_valid[i] & req_ready[i].
- mult_cfg  input  N_REQ*MULT_W  per-requester expansion factor; slice i is [i*MULT_W +: MULT_W].
- out_valid  output  1  expanded token present.
- out_ready  input  1  downstream accepts token.
- out_id  output  ID_W  owner of the current token.
- out_last  output  1  current token is the last of its burst.
- busy  output  1  FSM in EXPAND.

Behaviour:
- Reset (rst low, async): outputs go 0 immediately; out_valid, out_last, busy, req_ready, out_id and the counter are 0; FSM is IDLE; the round-robin pointer is 0 (requester 0 highest priority). Any burst in flight is dropped.
- FSM states: IDLE, EXPAND.
- can_accept = (state==IDLE) | (state==EXPAND & out_valid & out_ready & cnt==1).
- req_ready = rr_grant & {N_REQ{can_accept}}.
  - rr_grant is the one-hot round-robin pick over req_valid.
  - req_ready is combinational and may depend on req_valid.
- Accept of requester i:
  - latch id=i and cnt=mult_cfg[i]; mult_cfg is sampled only at accept.
  - the pointer moves so that i+1 mod N_REQ becomes highest priority.
- Accept with cnt!=0: next state EXPAND; first out_valid on the following cycle (latency 1).
- Accept with mult_cfg[i]==0: the request is consumed and no tokens are emitted.
  - From IDLE: state stays IDLE.
  - From the last-token cycle of EXPAND: next state is IDLE.
  - The pointer still advances.
- EXPAND:
  - out_valid=1, out_id=latched id, out_last=(cnt==1), busy=1.
  - On out_ready: cnt decrements.
  - On out_ready with cnt==1: next state is IDLE, or EXPAND with a new burst if an accept happens in the same cycle (zero bubble).
  - out_ready low: out_valid, out_id, out_last and cnt all hold.
- IDLE: out_valid=0, busy=0.
- Simultaneous requests: exactly one grant per cycle. Non-granted requesters keep req_valid high and wait.
- A requester dropping req_valid before it is granted is legal; nothing is recorded.
- Arithmetic: cnt is MULT_W bits and never wraps (decrements only while >=1).
- Maximum burst length is 2**MULT_W-1.

Optional Feature:
- Macro: TOKEN_ARB_STATS_EN.
- Defined:
  - adds output stat_tokens [N_REQ*16], a per-requester 16-bit count of accepted output tokens.
  - counts increment on out_valid & out_ready for out_id and saturate at 16'hFFFF.
  - cleared by reset only.
- Undefined: port and counters absent; behaviour otherwise identical.

Decomposition:
- Package token_arb_pkg: state enum (IDLE, EXPAND), MULT_W default and STAT_W=16 localparams.
- Sub-module rr_arbiter:
  - parameter N, inputs req[N], advance, outputs grant[N] (one-hot) and grant_idx.
  - owns the rotating priority pointer; the pointer updates only when advance=1.

Test Plan:
- Single request: reset, req_valid[2]=1 with mult_cfg[2]=3, out_ready=1. Required: req_ready[2] pulses once; the next 3 cycles give out_valid=1, out_id=2, out_last only on the 3rd; then busy=0.
- Round-robin fairness: all 4 req_valid held high, all mult=1, out_ready=1. Required: grant order 0,1,2,3,0,… with out_valid continuous and no bubbles.
- Backpressure: mult=2, out_ready low for 5 cycles mid-burst. Required: out_valid, out_id, out_last stable and no extra req_ready; the burst completes with exactly 2 handshakes.
- Zero factor: mult_cfg[1]=0 and mult_cfg[0]=2, both valid. Required: requester 0 burst, then requester 1 consumed with no out_valid, then the pointer makes requester 2 highest priority.
- Config change mid-burst: change mult_cfg[0] from 5 to 1 after accept. Required: still 5 tokens emitted.
- Async reset mid-burst: drive rst low mid-EXPAND with mult=6 at token 3. Required: out_valid/busy drop without waiting for a clock edge; after release, requester 0 is highest priority. With TOKEN_ARB_STATS_EN: stat_tokens are 0.
